// File: rtl/bg_layer_sequencer.sv
// bg_layer_sequencer: staggered per-layer line start, per-line pan latching,
// round-robin VRAM fetch-slot rotation, completion tracking and overrun detection
module bg_layer_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int PAN_W = 3,
  parameter int STAGGER = 2,
  localparam int IDX_W = $clog2(NUM_LAYERS > 2 ? NUM_LAYERS : 2)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        lineStarting,
  input  logic [NUM_LAYERS-1:0]       layerEnable,
  input  logic [NUM_LAYERS*PAN_W-1:0] panIn,
  input  logic [NUM_LAYERS-1:0]       layerDone,
  output logic [NUM_LAYERS-1:0]       layerStart,
  output logic [NUM_LAYERS*PAN_W-1:0] panOut,
  output logic [IDX_W-1:0]            fetchSlot,
  output logic [NUM_LAYERS-1:0]       fetchGrant,
  output logic                        lineBusy,
  output logic                        lineOverrun
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SEQ = 2'd1, S_RUN = 2'd2;
  localparam int LAST = (NUM_LAYERS - 1) * STAGGER;
  localparam int CNT_W = $clog2(LAST + 2);
  logic [1:0]                  r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [NUM_LAYERS-1:0]       r_active, r_started, r_done;
  logic [NUM_LAYERS*PAN_W-1:0] r_pan;
  logic [IDX_W-1:0]            r_slot;
  logic                        r_overrun;
  logic [NUM_LAYERS-1:0]       w_done_nxt, w_start, w_grant;
  logic                        w_busy, w_complete;
  // w_complete looks at this cycle's dones so a simultaneous finish is not an overrun
  always_comb begin
    w_busy = r_state != S_IDLE;
    w_done_nxt = r_done | (layerDone & r_active & r_started & {NUM_LAYERS{w_busy}});
    w_complete = &(w_done_nxt | ~r_active);
  end
  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    assign w_start[k] = (r_state == S_SEQ) && (r_cnt == CNT_W'(k * STAGGER)) && r_active[k];
    assign w_grant[k] = (r_slot == IDX_W'(k)) && r_active[k] && r_started[k] && !r_done[k];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_active  <= '0;
      r_started <= '0;
      r_done    <= '0;
      r_pan     <= '0;
      r_slot    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_slot    <= (lineStarting || r_slot == IDX_W'(NUM_LAYERS - 1)) ? '0 : r_slot + IDX_W'(1);
      r_overrun <= lineStarting && (r_state == S_SEQ || (r_state == S_RUN && !w_complete));
      for (int k = 0; k < NUM_LAYERS; k++)
        if (lineStarting && layerEnable[k]) r_pan[k*PAN_W +: PAN_W] <= panIn[k*PAN_W +: PAN_W];
      if (lineStarting) begin
        r_state   <= S_SEQ;
        r_cnt     <= '0;
        r_active  <= layerEnable;
        r_started <= '0;
        r_done    <= '0;
      end else begin
        r_done    <= w_done_nxt;
        r_started <= r_started | w_start;
        if (r_state == S_SEQ) begin
          r_cnt   <= r_cnt + CNT_W'(1);
          r_state <= (r_cnt == CNT_W'(LAST)) ? S_RUN : S_SEQ;
        end else if (r_state == S_RUN && w_complete) begin
          r_state <= S_IDLE;
        end
      end
    end
  end
  assign layerStart  = w_start;
  assign panOut      = r_pan;
  assign fetchSlot   = r_slot;
  assign fetchGrant  = w_grant;
  assign lineBusy    = w_busy;
  assign lineOverrun = r_overrun;
endmodule
